// File: rtl/axi_mem_pkg.sv
// -----------------------------------------------------------------------------
// axi_mem_pkg
// Shared definitions for the axi_mem_responder slice:
//   - AXI response codes (OKAY / SLVERR)
//   - write and read FSM state encodings
//   - idx_width(): index width needed to address DEPTH entries (minimum 1)
// -----------------------------------------------------------------------------
package axi_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/axi_mem_array.sv
// -----------------------------------------------------------------------------
// axi_mem_array
// DEPTH x 8-bit storage with one synchronous write port and one registered
// read port. The storage itself is never reset so it maps onto block RAM;
// only the read output register is cleared by reset.
// A same-address read/write on one edge returns the old byte.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset (read reg only)
//   wr_en, wr_idx, wr_data  write port
//   rd_en, rd_idx           read port; rd_data updates only when rd_en=1
//   rd_clear                with rd_en, load 0 instead of the stored byte
//   rd_data                 registered read data
// -----------------------------------------------------------------------------
module axi_mem_array
    import axi_mem_pkg::*;
#(
    parameter int DEPTH = 12,
    parameter int IDX_W = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [7:0]       wr_data,
    input  logic             rd_en,
    input  logic             rd_clear,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_data
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Non-blocking semantics give read-before-write on a collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_reg <= 8'h00;
        end else if (rd_en) begin
            rd_data_reg <= rd_clear ? 8'h00 : mem[rd_idx];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/axi_mem_responder.sv
// -----------------------------------------------------------------------------
// axi_mem_responder
// AXI4-Lite-style byte memory responder with independent write (AW/W/B) and
// read (AR/R) state machines, ID echo and full backpressure. All handshake
// outputs are registered; no valid input reaches a ready output
// combinationally.
//
// Optional feature macro: AXIMEM_ERR_EN
//   defined   : addresses >= DEPTH answer SLVERR, writes dropped, rdata=0
//   undefined : addresses wrap modulo DEPTH, response always OKAY
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   awvalid/awready/awaddr/awid write address channel
//   wvalid/wready/wdata        write data channel
//   bvalid/bready/bid/bresp    write response channel
//   arvalid/arready/araddr/arid read address channel
//   rvalid/rready/rdata/rid/rresp read data channel
// -----------------------------------------------------------------------------
module axi_mem_responder
    import axi_mem_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 12,
    parameter int ID_W   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [ID_W-1:0]   awid,
    input  logic              wvalid,
    output logic              wready,
    input  logic [7:0]        wdata,
    output logic              bvalid,
    input  logic              bready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [ID_W-1:0]   arid,
    output logic              rvalid,
    input  logic              rready,
    output logic [7:0]        rdata,
    output logic [ID_W-1:0]   rid,
    output logic [1:0]        rresp
);

    localparam int IDX_W = idx_width(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    w_state_t          w_state_reg;
    r_state_t          r_state_reg;
    logic              awready_reg, wready_reg, bvalid_reg;
    logic              arready_reg, rvalid_reg;
    logic [ID_W-1:0]   bid_reg, rid_reg;
    logic [1:0]        bresp_reg, rresp_reg;
    logic [IDX_W-1:0]  wr_idx_reg;
    logic              wr_ok_reg;

    logic              aw_ok, ar_ok;
    logic [IDX_W-1:0]  aw_idx, ar_idx;
    logic              aw_fire, w_fire, b_fire, ar_fire, r_fire;
    logic              wr_en;

    assign aw_fire = awvalid & awready_reg;
    assign w_fire  = wvalid  & wready_reg;
    assign b_fire  = bvalid_reg & bready;
    assign ar_fire = arvalid & arready_reg;
    assign r_fire  = rvalid_reg & rready;

    // Address legality and array index for both address channels.
    always_comb begin
`ifdef AXIMEM_ERR_EN
        aw_ok  = ({1'b0, awaddr} < DEPTH_C);
        ar_ok  = ({1'b0, araddr} < DEPTH_C);
        aw_idx = aw_ok ? awaddr[IDX_W-1:0] : '0;
        ar_idx = ar_ok ? araddr[IDX_W-1:0] : '0;
`else
        aw_ok  = 1'b1;
        ar_ok  = 1'b1;
        aw_idx = IDX_W'({1'b0, awaddr} % DEPTH_C);
        ar_idx = IDX_W'({1'b0, araddr} % DEPTH_C);
`endif
    end

    // Gating with reset keeps a W beat coincident with reset from committing.
    assign wr_en = w_fire & wr_ok_reg & ~reset;

    // Write FSM. bid/bresp are loaded at the AW handshake; they are only
    // observed once bvalid rises, and stay stable until the B handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_reg <= W_IDLE;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bid_reg     <= '0;
            bresp_reg   <= RESP_OKAY;
            wr_idx_reg  <= '0;
            wr_ok_reg   <= 1'b0;
        end else begin
            unique case (w_state_reg)
                W_IDLE: begin
                    if (aw_fire) begin
                        wr_idx_reg  <= aw_idx;
                        wr_ok_reg   <= aw_ok;
                        bid_reg     <= awid;
                        bresp_reg   <= aw_ok ? RESP_OKAY : RESP_SLVERR;
                        awready_reg <= 1'b0;
                        wready_reg  <= 1'b1;
                        w_state_reg <= W_DATA;
                    end else begin
                        awready_reg <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        wready_reg  <= 1'b0;
                        bvalid_reg  <= 1'b1;
                        w_state_reg <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (b_fire) begin
                        bvalid_reg  <= 1'b0;
                        awready_reg <= 1'b1;
                        w_state_reg <= W_IDLE;
                    end
                end
                default: begin
                    awready_reg <= 1'b0;
                    wready_reg  <= 1'b0;
                    bvalid_reg  <= 1'b0;
                    w_state_reg <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM. rdata comes from the array's registered read port, which
    // only updates on the AR handshake and so holds while rvalid waits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_reg <= R_IDLE;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rid_reg     <= '0;
            rresp_reg   <= RESP_OKAY;
        end else begin
            unique case (r_state_reg)
                R_IDLE: begin
                    if (ar_fire) begin
                        rid_reg     <= arid;
                        rresp_reg   <= ar_ok ? RESP_OKAY : RESP_SLVERR;
                        arready_reg <= 1'b0;
                        rvalid_reg  <= 1'b1;
                        r_state_reg <= R_DATA;
                    end else begin
                        arready_reg <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        rvalid_reg  <= 1'b0;
                        arready_reg <= 1'b1;
                        r_state_reg <= R_IDLE;
                    end
                end
                default: begin
                    arready_reg <= 1'b0;
                    rvalid_reg  <= 1'b0;
                    r_state_reg <= R_IDLE;
                end
            endcase
        end
    end

    axi_mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx_reg),
        .wr_data  (wdata),
        .rd_en    (ar_fire),
        .rd_clear (~ar_ok),
        .rd_idx   (ar_idx),
        .rd_data  (rdata)
    );

    assign awready = awready_reg;
    assign wready  = wready_reg;
    assign bvalid  = bvalid_reg;
    assign bid     = bid_reg;
    assign bresp   = bresp_reg;
    assign arready = arready_reg;
    assign rvalid  = rvalid_reg;
    assign rid     = rid_reg;
    assign rresp   = rresp_reg;

endmodule

// File: tb/tb_axi_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_axi_mem_responder
// Self-checking bench for axi_mem_responder (ADDR_W=4, DEPTH=12, ID_W=1).
// Expected responses are pushed to per-channel queues when a request is
// driven and popped when the response appears. Honors AXIMEM_ERR_EN.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_axi_mem_responder;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic       clk = 1'b0;
    logic       reset;
    logic       awvalid, awready;
    logic [3:0] awaddr;
    logic [0:0] awid;
    logic       wvalid, wready;
    logic [7:0] wdata;
    logic       bvalid, bready;
    logic [0:0] bid;
    logic [1:0] bresp;
    logic       arvalid, arready;
    logic [3:0] araddr;
    logic [0:0] arid;
    logic       rvalid, rready;
    logic [7:0] rdata;
    logic [0:0] rid;
    logic [1:0] rresp;

    typedef struct {
        logic [0:0] id;
        logic [1:0] resp;
        logic [7:0] data;
    } exp_t;

    exp_t       b_q[$];
    exp_t       r_q[$];
    logic [7:0] model_mem [12];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    axi_mem_responder #(.ADDR_W(4), .DEPTH(12), .ID_W(1)) dut (
        .clk(clk), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp)
    );

    // Reference memory behaviour: update on write, produce expected read.
    function automatic exp_t model_write(input logic [3:0] addr, input logic [0:0] id,
                                         input logic [7:0] data);
        exp_t e;
        e.id = id;
        e.data = 8'h00;
`ifdef AXIMEM_ERR_EN
        if (addr < 4'd12) begin
            model_mem[addr] = data;
            e.resp = OKAY;
        end else begin
            e.resp = SLVERR;
        end
`else
        model_mem[addr % 4'd12] = data;
        e.resp = OKAY;
`endif
        return e;
    endfunction

    function automatic exp_t model_read(input logic [3:0] addr, input logic [0:0] id);
        exp_t e;
        e.id = id;
`ifdef AXIMEM_ERR_EN
        if (addr < 4'd12) begin
            e.data = model_mem[addr];
            e.resp = OKAY;
        end else begin
            e.data = 8'h00;
            e.resp = SLVERR;
        end
`else
        e.data = model_mem[addr % 4'd12];
        e.resp = OKAY;
`endif
        return e;
    endfunction

    // AW + W, ending on the negedge after the W handshake.
    task automatic issue_write(input logic [3:0] addr, input logic [0:0] id, input logic [7:0] data);
        int cnt = 0;
        awaddr = addr; awid = id; awvalid = 1'b1;
        while (awready !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
        checks++;
        if (awready !== 1'b1) begin errors++; $display("FAIL aw_wait: awready=%b required 1", awready); end
        @(negedge clk);
        awvalid = 1'b0;
        checks++;
        if (wready !== 1'b1) begin errors++; $display("FAIL wready_after_aw: got %b required 1", wready); end
        wdata = data; wvalid = 1'b1;
        b_q.push_back(model_write(addr, id, data));
        @(negedge clk);
        wvalid = 1'b0;
        checks++;
        if (bvalid !== 1'b1) begin errors++; $display("FAIL bvalid_after_w: got %b required 1", bvalid); end
    endtask

    // AR, ending on the negedge after the AR handshake.
    task automatic issue_read(input logic [3:0] addr, input logic [0:0] id);
        int cnt = 0;
        araddr = addr; arid = id; arvalid = 1'b1;
        r_q.push_back(model_read(addr, id));
        while (arready !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
        checks++;
        if (arready !== 1'b1) begin errors++; $display("FAIL ar_wait: arready=%b required 1", arready); end
        @(negedge clk);
        arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1) begin errors++; $display("FAIL rvalid_after_ar: got %b required 1", rvalid); end
    endtask

    // Hold bready low for 'hold' cycles, then complete B.
    task automatic collect_b(input int hold);
        exp_t e;
        if (b_q.size() == 0) begin
            checks++; errors++; $display("FAIL b_queue_empty");
            return;
        end
        e = b_q.pop_front();
        for (int i = 0; i <= hold; i++) begin
            checks++;
            if (bvalid !== 1'b1 || bid !== e.id || bresp !== e.resp || awready !== 1'b0) begin
                errors++;
                $display("FAIL b_resp cyc%0d: bvalid=%b bid=%b bresp=%b awready=%b required 1 %b %b 0",
                         i, bvalid, bid, bresp, awready, e.id, e.resp);
            end
            if (i < hold) @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            errors++;
            $display("FAIL b_done: bvalid=%b awready=%b required 0 1", bvalid, awready);
        end
        $display("write resp id=%b resp=%b", e.id, e.resp);
    endtask

    task automatic collect_r(input int hold);
        exp_t e;
        if (r_q.size() == 0) begin
            checks++; errors++; $display("FAIL r_queue_empty");
            return;
        end
        e = r_q.pop_front();
        for (int i = 0; i <= hold; i++) begin
            checks++;
            if (rvalid !== 1'b1 || rdata !== e.data || rid !== e.id || rresp !== e.resp || arready !== 1'b0) begin
                errors++;
                $display("FAIL r_resp cyc%0d: rvalid=%b rdata=%h rid=%b rresp=%b arready=%b required 1 %h %b %b 0",
                         i, rvalid, rdata, rid, rresp, arready, e.data, e.id, e.resp);
            end
            if (i < hold) @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            errors++;
            $display("FAIL r_done: rvalid=%b arready=%b required 0 1", rvalid, arready);
        end
        $display("read resp id=%b data=%h resp=%b", e.id, e.data, e.resp);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({awready, wready, bvalid, rvalid, arready, bid, bresp, rid, rresp, rdata} !== 17'd0) begin
            errors++;
            $display("FAIL reset_values: aw=%b w=%b b=%b r=%b ar=%b bid=%b bresp=%b rid=%b rresp=%b rdata=%h required all 0",
                     awready, wready, bvalid, rvalid, arready, bid, bresp, rid, rresp, rdata);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (awready !== 1'b1 || arready !== 1'b1 || wready !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: awready=%b arready=%b wready=%b required 1 1 0", awready, arready, wready);
        end
        $display("reset done");
    endtask

    task automatic test_basic();
        issue_write(4'd3, 1'b1, 8'hA5);
        collect_b(0);
        issue_read(4'd3, 1'b0);
        collect_r(0);
    endtask

    task automatic test_backpressure();
        issue_write(4'd7, 1'b0, 8'h3C);
        collect_b(5);
        issue_read(4'd7, 1'b1);
        collect_r(4);
    endtask

    task automatic test_same_edge();
        int cnt = 0;
        issue_write(4'd5, 1'b0, 8'h11);
        collect_b(0);
        awaddr = 4'd5; awid = 1'b1; awvalid = 1'b1;
        while (awready !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
        @(negedge clk);
        awvalid = 1'b0;
        checks++;
        if (wready !== 1'b1 || arready !== 1'b1) begin
            errors++; $display("FAIL same_edge_setup: wready=%b arready=%b required 1 1", wready, arready);
        end
        // W and AR complete on the same rising edge.
        r_q.push_back(model_read(4'd5, 1'b1));
        b_q.push_back(model_write(4'd5, 1'b1, 8'h77));
        wdata = 8'h77; wvalid = 1'b1;
        araddr = 4'd5; arid = 1'b1; arvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0; arvalid = 1'b0;
        collect_b(0);
        collect_r(0);
        issue_read(4'd5, 1'b0);
        collect_r(0);
    endtask

    task automatic test_error();
        issue_write(4'd2, 1'b1, 8'h22);
        collect_b(0);
        issue_write(4'd14, 1'b0, 8'h5A);
        collect_b(0);
        issue_read(4'd14, 1'b1);
        collect_r(0);
        issue_read(4'd2, 1'b0);
        collect_r(0);
    endtask

    task automatic test_reset_mid();
        int cnt = 0;
        issue_write(4'd6, 1'b0, 8'h66);
        collect_b(0);
        awaddr = 4'd6; awid = 1'b1; awvalid = 1'b1;
        araddr = 4'd6; arid = 1'b1; arvalid = 1'b1;
        while ((awready !== 1'b1 || arready !== 1'b1) && cnt < 20) begin @(negedge clk); cnt++; end
        @(negedge clk);
        awvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (wready !== 1'b1 || rvalid !== 1'b1) begin
            errors++; $display("FAIL reset_mid_setup: wready=%b rvalid=%b required 1 1", wready, rvalid);
        end
        // W beat coincident with reset must not commit.
        wdata = 8'hEE; wvalid = 1'b1; reset = 1'b1;
        @(negedge clk);
        wvalid = 1'b0; reset = 1'b0;
        checks++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0 || wready !== 1'b0 || awready !== 1'b0 ||
            arready !== 1'b0 || rdata !== 8'h00 || rid !== 1'b0 || bid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: bvalid=%b rvalid=%b wready=%b awready=%b arready=%b rdata=%h rid=%b bid=%b required 0 0 0 0 0 00 0 0",
                     bvalid, rvalid, wready, awready, arready, rdata, rid, bid);
        end
        @(negedge clk);
        checks++;
        if (awready !== 1'b1 || arready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_release: awready=%b arready=%b required 1 1", awready, arready);
        end
        issue_read(4'd6, 1'b0);
        collect_r(0);
    endtask

    task automatic test_back_to_back();
        int cnt = 0;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            issue_write(4'(i), 1'(i), 8'($urandom_range(0, 255)));
            collect_b(0);
        end
        rready = 1'b1;
        araddr = 4'd0; arid = 1'b0; arvalid = 1'b1;
        r_q.push_back(model_read(4'd0, 1'b0));
        while (arready !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e = r_q.pop_front();
            checks++;
            if (rvalid !== 1'b1 || arready !== 1'b0 || rdata !== e.data || rid !== e.id || rresp !== e.resp) begin
                errors++;
                $display("FAIL b2b_read%0d: rvalid=%b arready=%b rdata=%h rid=%b rresp=%b required 1 0 %h %b %b",
                         k, rvalid, arready, rdata, rid, rresp, e.data, e.id, e.resp);
            end
            $display("b2b read addr=%0d data=%h", k, rdata);
            if (k < 3) begin
                araddr = 4'(k + 1); arid = 1'(k + 1);
                r_q.push_back(model_read(4'(k + 1), 1'(k + 1)));
            end else begin
                arvalid = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (rvalid !== 1'b0 || arready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_spacing%0d: rvalid=%b arready=%b required 0 1", k, rvalid, arready);
            end
        end
        rready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        awvalid = 1'b0; awaddr = '0; awid = '0;
        wvalid = 1'b0; wdata = '0; bready = 1'b0;
        arvalid = 1'b0; araddr = '0; arid = '0; rready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_same_edge();
        test_error();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (b_q.size() != 0 || r_q.size() != 0) begin
            errors++;
            $display("FAIL queues_drained: b=%0d r=%0d required 0 0", b_q.size(), r_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
